// File: rtl/dffr_ctrl_pkg.sv
// dffr_ctrl_pkg: shared op codes, FSM states and counter width for the flop-bank sequencer.
package dffr_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_CLEAR = 2'b01,
        OP_LOAD  = 2'b10,
        OP_READ  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SETUP,
        STROBE,
        SAMPLE,
        RESP
    } state_e;

endpackage

// File: rtl/dffr_seq_ctrl_if.sv
// dffr_seq_ctrl_if: command/response handshake between the register-file front end and the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_data/rsp_err: response channel (slave -> master)
interface dffr_seq_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/dffr_ctrl_timer.sv
// dffr_ctrl_timer: loadable down-counter with zero flag, timing the clear pulse and data setup.
//   clk, rst : clock, async active-high reset (count -> 0)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : reload value
//   zero     : count has reached 0 (counter then holds)
module dffr_ctrl_timer
    import dffr_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);

    assign zero = (cnt == '0);

endmodule

// File: rtl/dffr_seq_ctrl.sv
// dffr_seq_ctrl: sequences CLEAR/LOAD/READ commands onto a bank of clearable flip-flops.
//   clk, rst  : clock, async active-high reset (clears the bank, drops any response)
//   bus       : slave side of the command/response handshake
//   bank_clr_ : active-low clear to the bank
//   bank_d    : data to the bank, held until the next LOAD
//   bank_ce   : one-cycle capture enable
//   bank_q    : bank outputs, sampled by READ
module dffr_seq_ctrl
    import dffr_ctrl_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLR_CYCLES   = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    dffr_seq_ctrl_if.slave   bus,
    output logic             bank_clr_,
    output logic [WIDTH-1:0] bank_d,
    output logic             bank_ce,
    input  logic [WIDTH-1:0] bank_q
);

    state_e           state, state_n;
    logic             clr_n, ce_n, rv_n, re_n, rsp_valid, rsp_err;
    logic [WIDTH-1:0] d_n, rd_n, rsp_data;
    logic             tmr_zero;
    logic [CNT_W-1:0] tmr_val;

    assign bus.cmd_ready = (state == IDLE) && bank_clr_;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_err   = rsp_err;

    // Counter is reloaded on every state change; only CLR and SETUP use a non-zero value.
    assign tmr_val = state_n == CLR   ? CNT_W'(CLR_CYCLES - 1) :
                     state_n == SETUP ? CNT_W'(SETUP_CYCLES - 1) : '0;

    dffr_ctrl_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_n != state),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            bank_clr_ <= 1'b0;
            bank_d    <= '0;
            bank_ce   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            bank_clr_ <= clr_n;
            bank_d    <= d_n;
            bank_ce   <= ce_n;
            rsp_valid <= rv_n;
            rsp_data  <= rd_n;
            rsp_err   <= re_n;
        end

    always_comb begin
        state_n = state;
        clr_n   = bank_clr_;
        d_n     = bank_d;
        ce_n    = 1'b0;
        rv_n    = rsp_valid;
        rd_n    = rsp_data;
        re_n    = rsp_err;
        case (state)
            IDLE:
                // The first post-reset cycle releases the clear before any command is taken.
                if (!bank_clr_)
                    clr_n = 1'b1;
                else if (bus.cmd_valid)
                    case (op_e'(bus.cmd_op))
                        OP_CLEAR: begin
                            state_n = CLR;
                            clr_n   = 1'b0;
                        end
                        OP_LOAD: begin
                            state_n = SETUP;
                            d_n     = bus.cmd_data;
                        end
                        OP_READ:
                            state_n = SAMPLE;
                        default: begin
                            state_n = RESP;
                            rv_n    = 1'b1;
                            rd_n    = '0;
                            re_n    = 1'b1;
                        end
                    endcase
            CLR:
                // Release the clear when the timer expires, then spend one recovery cycle.
                if (!bank_clr_) begin
                    if (tmr_zero)
                        clr_n = 1'b1;
                end else begin
                    state_n = RESP;
                    rv_n    = 1'b1;
                    rd_n    = '0;
                    re_n    = 1'b0;
                end
            SETUP:
                if (tmr_zero) begin
                    state_n = STROBE;
                    ce_n    = 1'b1;
                end
            STROBE: begin
                state_n = RESP;
                rv_n    = 1'b1;
                rd_n    = '0;
                re_n    = 1'b0;
            end
            SAMPLE: begin
                state_n = RESP;
                rv_n    = 1'b1;
                rd_n    = bank_q;
                re_n    = 1'b0;
            end
            RESP:
                if (bus.rsp_ready) begin
                    state_n = IDLE;
                    rv_n    = 1'b0;
                    re_n    = 1'b0;
                end
            default:
                state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dffr_seq_ctrl.sv
// tb_dffr_seq_ctrl: drives three sequencers (default, CLR=1/SETUP=15, CLR=15/SETUP=15) with shared commands.
module tb_dffr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_ready;
    logic [2:0] rdy, rv, re, clr_n, ce;
    logic [7:0] rd [3];
    logic [7:0] bd [3];
    logic [7:0] bq [3];

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq;
    logic [7:0] md;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        dffr_seq_ctrl_if #(.WIDTH(8)) bus ();
        assign bus.cmd_valid = cmd_valid;
        assign bus.cmd_op    = cmd_op;
        assign bus.cmd_data  = cmd_data;
        assign bus.rsp_ready = rsp_ready;
        assign rdy[g]        = bus.cmd_ready;
        assign rv[g]         = bus.rsp_valid;
        assign rd[g]         = bus.rsp_data;
        assign re[g]         = bus.rsp_err;
        dffr_seq_ctrl #(
            .WIDTH        (8),
            .CLR_CYCLES   (g == 0 ? 2 : g == 1 ? 1 : 15),
            .SETUP_CYCLES (g == 0 ? 1 : 15)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .bus       (bus),
            .bank_clr_ (clr_n[g]),
            .bank_d    (bd[g]),
            .bank_ce   (ce[g]),
            .bank_q    (bq[g])
        );
        always @(posedge clk or negedge clr_n[g])
            if (!clr_n[g])
                bq[g] <= '0;
            else if (ce[g])
                bq[g] <= bd[g];
    end

    function automatic int clr_p(int i);
        return i == 0 ? 2 : i == 1 ? 1 : 15;
    endfunction

    function automatic int set_p(int i);
        return i == 0 ? 1 : 15;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("mutex dut%0d", i), {31'd0, !clr_n[i] && ce[i]}, 0);
    endtask

    task automatic wait_ready();
        for (int n = 0; n < 40 && rdy !== 3'b111; n++)
            tick();
        chk("wait_ready", {29'd0, rdy}, 7);
    endtask

    // Issues one command with rsp_ready held high and checks every instance's timing
    // against the latencies implied by its own CLR_CYCLES/SETUP_CYCLES.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] data);
        int rk[3], ck[3], cn[3], lo[3], vn[3];
        logic [7:0] rdv[3];
        logic rev[3];
        int erk, eck, ecn, elo;
        wait_ready();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 0; i < 3; i++) begin
            rk[i] = -1; ck[i] = -1; cn[i] = 0; lo[i] = 0; vn[i] = 0; rdv[i] = 'x; rev[i] = 1'bx;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (rv[i]) begin
                    vn[i]++;
                    if (rk[i] < 0) begin
                        rk[i] = k; rdv[i] = rd[i]; rev[i] = re[i];
                    end
                end
                if (ce[i]) begin
                    cn[i]++;
                    if (ck[i] < 0) ck[i] = k;
                end
                if (!clr_n[i]) lo[i]++;
            end
            if (k < 19) tick();
        end
        for (int i = 0; i < 3; i++) begin
            erk = op == 2'b00 ? 0 : op == 2'b11 ? 1 : op == 2'b01 ? clr_p(i) + 1 : set_p(i) + 1;
            eck = op == 2'b10 ? set_p(i) : -1;
            ecn = op == 2'b10 ? 1 : 0;
            elo = op == 2'b01 ? clr_p(i) : 0;
            chk($sformatf("op%0d dut%0d rsp_lat", op, i), rk[i], erk);
            chk($sformatf("op%0d dut%0d rsp_cycles", op, i), vn[i], 1);
            chk($sformatf("op%0d dut%0d rsp_data", op, i), {24'd0, rdv[i]}, op == 2'b11 ? {24'd0, mq} : 0);
            chk($sformatf("op%0d dut%0d rsp_err", op, i), {31'd0, rev[i]}, op == 2'b00 ? 1 : 0);
            chk($sformatf("op%0d dut%0d ce_edge", op, i), ck[i], eck);
            chk($sformatf("op%0d dut%0d ce_cycles", op, i), cn[i], ecn);
            chk($sformatf("op%0d dut%0d clr_cycles", op, i), lo[i], elo);
        end
        if (op == 2'b01) mq = 8'h00;
        if (op == 2'b10) begin
            mq = data;
            md = data;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("op%0d dut%0d bank_d", op, i), {24'd0, bd[i]}, {24'd0, md});
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        mq        = 8'h00;
        md        = 8'h00;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("rst clr", {29'd0, clr_n}, 0);
            chk("rst ready", {29'd0, rdy}, 0);
            chk("rst rsp_valid", {29'd0, rv}, 0);
            chk("rst ce", {29'd0, ce}, 0);
            chk("rst bank_d", {24'd0, bd[0]}, 0);
            tick();
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst clr before edge", {29'd0, clr_n}, 0);
        chk("post_rst ready before edge", {29'd0, rdy}, 0);
        tick();
        chk("post_rst clr", {29'd0, clr_n}, 7);
        chk("post_rst ready", {29'd0, rdy}, 7);

        run_cmd(2'b01, 8'h00);
        run_cmd(2'b10, 8'hA5);
        run_cmd(2'b11, 8'h00);

        // Backpressure: hold the READ response, with a LOAD queued behind it.
        wait_ready();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        tick();
        cmd_op    = 2'b10;
        cmd_data  = 8'h3C;
        tick();
        for (int c = 0; c < 6; c++) begin
            chk("bp rsp_valid", {29'd0, rv}, 7);
            chk("bp ready", {29'd0, rdy}, 0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("bp rsp_data dut%0d", i), {24'd0, rd[i]}, {24'd0, mq});
            if (c < 5) tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp release rsp_valid", {29'd0, rv}, 0);
        chk("bp release ready", {29'd0, rdy}, 7);
        tick();
        chk("bp queued accept", {29'd0, rdy}, 0);
        chk("bp queued bank_d", {24'd0, bd[0]}, 32'h3C);
        cmd_valid = 1'b0;
        mq = 8'h3C;
        md = 8'h3C;
        run_cmd(2'b11, 8'h00);

        run_cmd(2'b00, 8'hFF);

        // Reset in the middle of a LOAD's setup window.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 8'h5A;
        tick();
        cmd_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst clr", {29'd0, clr_n}, 0);
        chk("mid_rst ce", {29'd0, ce}, 0);
        chk("mid_rst rsp_valid", {29'd0, rv}, 0);
        chk("mid_rst ready", {29'd0, rdy}, 0);
        chk("mid_rst bank_d", {24'd0, bd[0]}, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mid_rst hold ce", {29'd0, ce}, 0);
            chk("mid_rst hold clr", {29'd0, clr_n}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        mq  = 8'h00;
        md  = 8'h00;
        #1;
        chk("mid_rst ready before edge", {29'd0, rdy}, 0);
        tick();
        chk("mid_rst ready after edge", {29'd0, rdy}, 7);
        run_cmd(2'b11, 8'h00);

        repeat (16)
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom));
        run_cmd(2'b11, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
